// File: rtl/instr_fetch_unit.sv
// ----------------------------------------------------------------------------
// instr_fetch_unit
//
// Instruction fetch stage feeding the decoder. Holds the PC, issues word reads
// to a synchronous instruction memory (data returns one cycle after the
// request), buffers returned instructions with their fetch address in a small
// prefetch FIFO, and presents the FIFO head over a valid/ready handshake.
// A redirect pulse flushes the buffer, squashes any in-flight response and
// restarts fetch at a new PC.
//
// Optional feature: define FETCH_HALT_EN to stop fetching after an instruction
// whose opcode (bits [31:28]) is 4'hF. Without it, halted is tied low and
// opcode 4'hF is an ordinary instruction.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   imem_req/addr   read request and word address (addr always equals pc)
//   imem_rdata      read data, valid the cycle after imem_req
//   redirect_*      1-cycle redirect pulse and its target PC
//   out_valid/ready handshake towards decode
//   out_instr/pc    FIFO head instruction and the address it came from
//   halted          fetch stopped on a HALT opcode (FETCH_HALT_EN only)
// ----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int unsigned        ADDR_W     = 8,
    parameter int unsigned        FIFO_DEPTH = 4,
    parameter logic [ADDR_W-1:0]  RESET_PC   = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_pc,
    output logic              halted
);

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              inflight_q, inflight_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic [PtrW-1:0]   wptr_q, wptr_d;
    logic [PtrW-1:0]   rptr_q, rptr_d;
    logic [CntW-1:0]   count_q, count_d;

    logic [31:0]       fifo_instr_q [FIFO_DEPTH];
    logic [ADDR_W-1:0] fifo_pc_q    [FIFO_DEPTH];

    logic              push;
    logic              pop;
    logic              fetch_stop;
    logic [CntW-1:0]   used;

    // Slots already claimed: buffered entries plus the response still on its way.
    assign used      = count_q + CntW'(inflight_q);
    assign imem_req  = !rst && !redirect_valid && !fetch_stop && (used < CntW'(FIFO_DEPTH));
    assign imem_addr = pc_q;

    // A redirect squashes the response arriving this cycle.
    assign push      = inflight_q && !redirect_valid;
    assign out_valid = (count_q != '0);
    assign pop       = out_valid && out_ready;
    assign out_instr = fifo_instr_q[rptr_q];
    assign out_pc    = fifo_pc_q[rptr_q];

`ifdef FETCH_HALT_EN
    logic halted_q;
    logic halt_resp;

    assign halt_resp  = inflight_q && (imem_rdata[31:28] == 4'hF);
    // Block the request in the HALT response cycle so nothing past it is fetched.
    assign fetch_stop = halted_q || halt_resp;
    assign halted     = halted_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            halted_q <= 1'b0;
        end else if (redirect_valid) begin
            halted_q <= 1'b0;
        end else if (push && halt_resp) begin
            halted_q <= 1'b1;
        end
    end
`else
    assign fetch_stop = 1'b0;
    assign halted     = 1'b0;
`endif

    always_comb begin
        pc_d       = pc_q;
        inflight_d = inflight_q;
        req_addr_d = req_addr_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;

        if (redirect_valid) begin
            // Flush; a pop this cycle is simply absorbed by the flush.
            pc_d       = redirect_pc;
            inflight_d = 1'b0;
            wptr_d     = '0;
            rptr_d     = '0;
            count_d    = '0;
        end else begin
            inflight_d = imem_req;
            if (imem_req) begin
                pc_d       = pc_q + ADDR_W'(1);
                req_addr_d = pc_q;
            end
            if (push) begin
                wptr_d = wptr_q + PtrW'(1);
            end
            if (pop) begin
                rptr_d = rptr_q + PtrW'(1);
            end
            count_d = count_q + CntW'(push) - CntW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            inflight_q <= 1'b0;
            req_addr_q <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            req_addr_q <= req_addr_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible through count_q.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            fifo_instr_q[wptr_q] <= imem_rdata;
            fifo_pc_q[wptr_q]    <= req_addr_q;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ----------------------------------------------------------------------------
// Testbench for instr_fetch_unit: directed vector table from reset, PC wrap
// with RESET_PC=8'hFE, HALT behaviour, and a randomized run against a
// transaction-level model of the fetch stream.
// ----------------------------------------------------------------------------
module tb_instr_fetch_unit;

    localparam int unsigned AW    = 8;
    localparam int unsigned DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          redirect_valid = 1'b0;
    logic [AW-1:0] redirect_pc = '0;
    logic          out_ready = 1'b0;

    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_rdata;
    logic          out_valid;
    logic [31:0]   out_instr;
    logic [AW-1:0] out_pc;
    logic          halted;

    logic          fe_req;
    logic [AW-1:0] fe_addr;
    logic [31:0]   fe_rdata;
    logic          fe_valid;
    logic [31:0]   fe_instr;
    logic [AW-1:0] fe_pc;
    logic          fe_halted;
    logic          fe_ready = 1'b1;
    logic          fe_redir = 1'b0;
    logic [AW-1:0] fe_rpc = '0;

    logic [31:0]   mem [256];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    instr_fetch_unit #(.ADDR_W(AW), .FIFO_DEPTH(DEPTH), .RESET_PC(8'h00)) u_dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .halted         (halted)
    );

    instr_fetch_unit #(.ADDR_W(AW), .FIFO_DEPTH(DEPTH), .RESET_PC(8'hFE)) u_dut_fe (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (fe_req),
        .imem_addr      (fe_addr),
        .imem_rdata     (fe_rdata),
        .redirect_valid (fe_redir),
        .redirect_pc    (fe_rpc),
        .out_valid      (fe_valid),
        .out_ready      (fe_ready),
        .out_instr      (fe_instr),
        .out_pc         (fe_pc),
        .halted         (fe_halted)
    );

    // Synchronous instruction memories: data one cycle after the request.
    always @(posedge clk) begin
        if (imem_req) imem_rdata <= mem[imem_addr];
        if (fe_req)   fe_rdata   <= mem[fe_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic          rst;
        logic          rdy;
        logic          redir;
        logic [AW-1:0] rpc;
        logic          req;
        logic [AW-1:0] addr;
        logic          valid;
        logic [AW-1:0] pc;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic rd, input logic rv,
                                input logic [AW-1:0] rp, input logic q,
                                input logic [AW-1:0] a, input logic v,
                                input logic [AW-1:0] p);
        vec_t t;
        t.rst = r; t.rdy = rd; t.redir = rv; t.rpc = rp;
        t.req = q; t.addr = a; t.valid = v; t.pc = p;
        return t;
    endfunction

    vec_t tbl [22];

    initial begin
        logic [AW-1:0] fe_exp [4];
        logic [AW-1:0] dq [$];
        logic [AW-1:0] max_req;
        logic [AW-1:0] max_addr;
        int            n_exp;
        // Random-phase model state
        logic [AW-1:0] fetch_pc;
        logic [AW-1:0] exp_pc;
        int            outstanding;
        int            inflight_m;
        logic          r_rst, r_redir, exp_req, exp_valid;
        logic [AW-1:0] r_pc;

        for (int i = 0; i < 256; i++) mem[i] = 32'(i);

        // Cycle-by-cycle expectations from reset, memory holding mem[i] = i.
        //             rst rdy rdr rpc     req addr   vld pc
        tbl[0]  = mk(1, 1, 0, 8'h00, 0, 8'h00, 0, 8'h00);
        tbl[1]  = mk(0, 1, 0, 8'h00, 1, 8'h00, 0, 8'h00);
        tbl[2]  = mk(0, 1, 0, 8'h00, 1, 8'h01, 0, 8'h00);
        tbl[3]  = mk(0, 1, 0, 8'h00, 1, 8'h02, 1, 8'h00);
        tbl[4]  = mk(0, 1, 0, 8'h00, 1, 8'h03, 1, 8'h01);
        tbl[5]  = mk(0, 1, 0, 8'h00, 1, 8'h04, 1, 8'h02);
        tbl[6]  = mk(0, 0, 0, 8'h00, 1, 8'h05, 1, 8'h03);
        tbl[7]  = mk(0, 0, 0, 8'h00, 1, 8'h06, 1, 8'h03);
        tbl[8]  = mk(0, 0, 0, 8'h00, 0, 8'h07, 1, 8'h03);
        tbl[9]  = mk(0, 0, 0, 8'h00, 0, 8'h07, 1, 8'h03);
        tbl[10] = mk(0, 1, 0, 8'h00, 0, 8'h07, 1, 8'h03);
        tbl[11] = mk(0, 1, 0, 8'h00, 1, 8'h07, 1, 8'h04);
        tbl[12] = mk(0, 1, 0, 8'h00, 1, 8'h08, 1, 8'h05);
        tbl[13] = mk(0, 1, 1, 8'h40, 0, 8'h09, 1, 8'h06);
        tbl[14] = mk(0, 1, 0, 8'h00, 1, 8'h40, 0, 8'h00);
        tbl[15] = mk(0, 1, 0, 8'h00, 1, 8'h41, 0, 8'h00);
        tbl[16] = mk(0, 1, 0, 8'h00, 1, 8'h42, 1, 8'h40);
        tbl[17] = mk(0, 0, 0, 8'h00, 1, 8'h43, 1, 8'h41);
        tbl[18] = mk(1, 0, 0, 8'h00, 0, 8'h44, 1, 8'h41);
        tbl[19] = mk(0, 1, 0, 8'h00, 1, 8'h00, 0, 8'h00);
        tbl[20] = mk(0, 1, 0, 8'h00, 1, 8'h01, 0, 8'h00);
        tbl[21] = mk(0, 1, 0, 8'h00, 1, 8'h02, 1, 8'h00);

        repeat (2) @(posedge clk);

        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            rst            = tbl[i].rst;
            out_ready      = tbl[i].rdy;
            redirect_valid = tbl[i].redir;
            redirect_pc    = tbl[i].rpc;
            #1;
            check($sformatf("tbl%0d imem_req", i), 32'(imem_req), 32'(tbl[i].req));
            check($sformatf("tbl%0d imem_addr", i), 32'(imem_addr), 32'(tbl[i].addr));
            check($sformatf("tbl%0d out_valid", i), 32'(out_valid), 32'(tbl[i].valid));
            if (tbl[i].valid) begin
                check($sformatf("tbl%0d out_pc", i), 32'(out_pc), 32'(tbl[i].pc));
                check($sformatf("tbl%0d out_instr", i), out_instr, 32'(tbl[i].pc));
            end
        end

        // PC wrap from RESET_PC = 8'hFE.
        fe_exp[0] = 8'hFE; fe_exp[1] = 8'hFF; fe_exp[2] = 8'h00; fe_exp[3] = 8'h01;
        @(negedge clk);
        rst = 1'b1; redirect_valid = 1'b0; out_ready = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            rst = 1'b0;
            #1;
            if (c == 1) begin
                check("fe first req", 32'(fe_req), 32'd1);
                check("fe first addr", 32'(fe_addr), 32'hFE);
            end
            if (c >= 3) begin
                check($sformatf("fe valid c%0d", c), 32'(fe_valid), 32'd1);
                check($sformatf("fe pc c%0d", c), 32'(fe_pc), 32'(fe_exp[c-3]));
                check($sformatf("fe instr c%0d", c), fe_instr, 32'(fe_exp[c-3]));
            end
        end

        // HALT opcode at address 5.
        mem[5] = 32'hF000_0000;
        @(negedge clk);
        rst = 1'b1; out_ready = 1'b1; redirect_valid = 1'b0;
        max_req = '0; max_addr = '0;
        dq.delete();
        @(negedge clk);
        rst = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (c > 1) @(negedge clk);
            #1;
            if (out_valid && out_ready) dq.push_back(out_pc);
            if (imem_req && imem_addr > max_req) max_req = imem_addr;
            if (imem_addr > max_addr) max_addr = imem_addr;
        end
`ifdef FETCH_HALT_EN
        n_exp = 6;
`else
        n_exp = 18;
`endif
        check("halt delivered count", 32'(dq.size()), 32'(n_exp));
        for (int i = 0; i < dq.size() && i < n_exp; i++) begin
            check($sformatf("halt seq %0d", i), 32'(dq[i]), 32'(i));
        end
`ifdef FETCH_HALT_EN
        check("halt max req addr", 32'(max_req), 32'd5);
        check("halt imem_addr bound", 32'(max_addr <= 8'd6), 32'd1);
        check("halted set", 32'(halted), 32'd1);
        check("halted no req", 32'(imem_req), 32'd0);
        @(negedge clk);
        redirect_valid = 1'b1; redirect_pc = 8'h00;
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        check("halt cleared", 32'(halted), 32'd0);
        check("resume req", 32'(imem_req), 32'd1);
        check("resume addr", 32'(imem_addr), 32'd0);
`else
        check("halted tied low", 32'(halted), 32'd0);
`endif

        // Randomized run against a transaction-level model.
        for (int i = 0; i < 256; i++) begin
            mem[i] = $urandom;
            if (mem[i][31:28] == 4'hF) mem[i][31:28] = 4'h0;
        end
        @(negedge clk);
        rst = 1'b1; redirect_valid = 1'b0;
        fetch_pc = 8'h00; exp_pc = 8'h00; outstanding = 0; inflight_m = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            r_rst   = ($urandom_range(0, 199) == 0);
            r_redir = ($urandom_range(0, 29) == 0);
            r_pc    = AW'($urandom);
            rst            = r_rst;
            redirect_valid = r_redir;
            redirect_pc    = r_pc;
            out_ready      = ($urandom_range(0, 9) < 7);
            #1;
            exp_req   = !r_rst && !r_redir && (outstanding < DEPTH);
            exp_valid = (outstanding - inflight_m) != 0;
            check("rnd imem_req", 32'(imem_req), 32'(exp_req));
            if (exp_req) check("rnd imem_addr", 32'(imem_addr), 32'(fetch_pc));
            check("rnd out_valid", 32'(out_valid), 32'(exp_valid));
            if (exp_valid) begin
                check("rnd out_pc", 32'(out_pc), 32'(exp_pc));
                check("rnd out_instr", out_instr, mem[exp_pc]);
            end
            if (r_rst) begin
                fetch_pc = 8'h00; exp_pc = 8'h00; outstanding = 0; inflight_m = 0;
            end else if (r_redir) begin
                fetch_pc = r_pc; exp_pc = r_pc; outstanding = 0; inflight_m = 0;
            end else begin
                if (exp_valid && out_ready) begin
                    exp_pc++;
                    outstanding--;
                end
                if (exp_req) begin
                    fetch_pc++;
                    outstanding++;
                end
                inflight_m = exp_req ? 1 : 0;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
